// File: rtl/mmc1_cfg_sequencer.sv
// Purpose: queues host register writes and plays each one onto the CPU bus as MMC1 serial shift writes; optional MMC1_AUTO_RESET_EN prefixes every register command with a reset write.
// Latency: a command pushed into an empty queue at edge t shows SETUP after edge t+2; each write takes M2_LO_CLKS+ROMSEL_DLY+M2_HI_CLKS+1+GAP_CLKS clocks.
// Backpressure: cmd_ready is low whenever the registered queue level equals FIFO_DEPTH, including a cycle in which a pop occurs.
module mmc1_cfg_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int M2_LO_CLKS = 6,
    parameter int ROMSEL_DLY = 1,
    parameter int M2_HI_CLKS = 5,
    parameter int GAP_CLKS   = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_reset,
    input  logic [1:0]                  cmd_reg,
    input  logic [4:0]                  cmd_data,
    output logic                        cmd_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        CPU_M2,
    output logic                        nCPU_ROMSEL,
    output logic                        nCPU_RW,
    output logic                        CPU_A14,
    output logic                        CPU_A13,
    output logic                        CPU_D0,
    output logic                        CPU_D7,
    output logic [4:0]                  shadow_control,
    output logic [4:0]                  shadow_chr0,
    output logic [4:0]                  shadow_chr1,
    output logic [4:0]                  shadow_prg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_DLY     = 3'd2;
    localparam logic [2:0] S_STROBE  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

`ifdef MMC1_AUTO_RESET_EN
    localparam logic AUTO_RST = 1'b1;
`else
    localparam logic AUTO_RST = 1'b0;
`endif

    // Queue storage: entry = {reset, reg[1:0], data[4:0]}
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    // Sequencer state
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          loaded_q, loaded_d;
    logic [6:0]    cmd_q, cmd_d;          // {reg, data} of the active command
    logic          rst_pend_q, rst_pend_d;  // a D7 reset write is still owed
    logic          data_pend_q, data_pend_d; // the five data writes are still owed
    logic [2:0]    bit_q, bit_d;
    logic          cmd_done_q, cmd_done_d;
    logic [4:0]    sh_ctl_q, sh_ctl_d, sh_c0_q, sh_c0_d, sh_c1_q, sh_c1_d, sh_prg_q, sh_prg_d;

    // Registered bus pins so the mapper never sees decode glitches
    logic          m2_q, m2_d, romsel_n_q, romsel_n_d, rw_n_q, rw_n_d;
    logic [1:0]    addr_q, addr_d;
    logic          d0_q, d0_d, d7_q, d7_d;

    logic          end_wr, last;
    logic [1:0]    wr_a;
    logic          wr_d0, wr_d7;

    assign cmd_ready = (level_q < LW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;

    // Next-state logic: queue pointers, write sequencing, shadow updates and bus decode
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        cmd_d       = cmd_q;
        rst_pend_d  = rst_pend_q;
        data_pend_d = data_pend_q;
        bit_d       = bit_q;
        cmd_done_d  = 1'b0;
        sh_ctl_d    = sh_ctl_q;
        sh_c0_d     = sh_c0_q;
        sh_c1_d     = sh_c1_q;
        sh_prg_d    = sh_prg_q;
        pop         = 1'b0;
        end_wr      = 1'b0;
        last        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // One clock to pull the entry out of the queue, one to start driving it
                if (loaded_q) begin
                    loaded_d = 1'b0;
                    state_d  = S_SETUP;
                    cnt_d    = CW'(M2_LO_CLKS - 1);
                end else if (level_q != '0) begin
                    pop         = 1'b1;
                    loaded_d    = 1'b1;
                    cmd_d       = mem_q[rd_ptr_q][6:0];
                    rst_pend_d  = mem_q[rd_ptr_q][7] | AUTO_RST;
                    data_pend_d = ~mem_q[rd_ptr_q][7];
                    bit_d       = 3'd0;
                end
            end
            S_SETUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (ROMSEL_DLY > 0) begin
                    state_d = S_DLY;
                    cnt_d   = CW'(ROMSEL_DLY - 1);
                end else begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(M2_HI_CLKS - 1);
                end
            end
            S_DLY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_STROBE;
                    cnt_d   = CW'(M2_HI_CLKS - 1);
                end
            end
            S_STROBE: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (GAP_CLKS > 0) begin
                    state_d = S_GAP;
                    cnt_d   = CW'(GAP_CLKS - 1);
                end else begin
                    end_wr = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             end_wr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A write has fully retired: account for it and pick the next one
        if (end_wr) begin
            if (rst_pend_q) begin
                rst_pend_d     = 1'b0;
                sh_ctl_d[3:2]  = 2'b11;
                last           = ~data_pend_q;
            end else begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd4) begin
                    last        = 1'b1;
                    data_pend_d = 1'b0;
                    case (cmd_q[6:5])
                        2'b00:   sh_ctl_d = cmd_q[4:0];
                        2'b01:   sh_c0_d  = cmd_q[4:0];
                        2'b10:   sh_c1_d  = cmd_q[4:0];
                        default: sh_prg_d = cmd_q[4:0];
                    endcase
                end
            end
            if (last) begin
                state_d    = S_IDLE;
                cmd_done_d = 1'b1;
            end else begin
                state_d = S_SETUP;
                cnt_d   = CW'(M2_LO_CLKS - 1);
            end
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        // Bus decode from the state being entered, so pins line up with state_q
        wr_a  = rst_pend_d ? 2'b00 : cmd_d[6:5];
        wr_d0 = rst_pend_d ? 1'b0  : cmd_d[bit_d];
        wr_d7 = rst_pend_d;

        m2_d       = 1'b0;
        romsel_n_d = 1'b1;
        rw_n_d     = 1'b1;
        addr_d     = 2'b00;
        d0_d       = 1'b0;
        d7_d       = 1'b0;
        if (state_d == S_SETUP || state_d == S_DLY || state_d == S_STROBE || state_d == S_RELEASE) begin
            m2_d       = (state_d != S_SETUP);
            romsel_n_d = (state_d != S_STROBE);
            rw_n_d     = 1'b0;
            addr_d     = wr_a;
            d0_d       = wr_d0;
            d7_d       = wr_d7;
        end
    end

    // Queue storage needs no reset; the pointers define what is valid
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_reset, cmd_reg, cmd_data};
    end

    // State registers with synchronous reset; reset aborts any write in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            cmd_q       <= '0;
            rst_pend_q  <= 1'b0;
            data_pend_q <= 1'b0;
            bit_q       <= '0;
            cmd_done_q  <= 1'b0;
            sh_ctl_q    <= 5'b01100;
            sh_c0_q     <= '0;
            sh_c1_q     <= '0;
            sh_prg_q    <= '0;
            m2_q        <= 1'b0;
            romsel_n_q  <= 1'b1;
            rw_n_q      <= 1'b1;
            addr_q      <= 2'b00;
            d0_q        <= 1'b0;
            d7_q        <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            cmd_q       <= cmd_d;
            rst_pend_q  <= rst_pend_d;
            data_pend_q <= data_pend_d;
            bit_q       <= bit_d;
            cmd_done_q  <= cmd_done_d;
            sh_ctl_q    <= sh_ctl_d;
            sh_c0_q     <= sh_c0_d;
            sh_c1_q     <= sh_c1_d;
            sh_prg_q    <= sh_prg_d;
            m2_q        <= m2_d;
            romsel_n_q  <= romsel_n_d;
            rw_n_q      <= rw_n_d;
            addr_q      <= addr_d;
            d0_q        <= d0_d;
            d7_q        <= d7_d;
        end
    end

    assign cmd_done       = cmd_done_q;
    assign busy           = (state_q != S_IDLE) || loaded_q || (level_q != '0);
    assign fifo_level     = level_q;
    assign CPU_M2         = m2_q;
    assign nCPU_ROMSEL    = romsel_n_q;
    assign nCPU_RW        = rw_n_q;
    assign CPU_A14        = addr_q[1];
    assign CPU_A13        = addr_q[0];
    assign CPU_D0         = d0_q;
    assign CPU_D7         = d7_q;
    assign shadow_control = sh_ctl_q;
    assign shadow_chr0    = sh_c0_q;
    assign shadow_chr1    = sh_c1_q;
    assign shadow_prg     = sh_prg_q;

endmodule

// File: tb/tb_mmc1_cfg_sequencer.sv
// Testbench for mmc1_cfg_sequencer: default-timing instance plus a ROMSEL_DLY=0/GAP_CLKS=0 instance.
// Expected bus writes and completions are queued at command issue and popped by a negedge monitor.
// All waits on the DUT are cycle-bounded.
module tb_mmc1_cfg_sequencer;

`ifdef MMC1_AUTO_RESET_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int NREG    = AUTO ? 6 : 5;
    localparam int WR_CLKS = 15;

    typedef struct packed { logic [1:0] a; logic d0; logic d7; } wr_t;
    typedef struct packed { logic [4:0] ctl; logic [4:0] c0; logic [4:0] c1; logic [4:0] prg; logic [7:0] nwr; } done_t;

    logic CLK = 1'b0, RST = 1'b1;
    logic cmd_valid = 1'b0, cmd_reset = 1'b0;
    logic [1:0] cmd_reg = '0;
    logic [4:0] cmd_data = '0;
    logic cmd_ready, cmd_done, busy, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7;
    logic [2:0] fifo_level;
    logic [4:0] shadow_control, shadow_chr0, shadow_chr1, shadow_prg;

    logic b_valid = 1'b0;
    logic [1:0] b_reg = '0;
    logic [4:0] b_data = '0;
    logic b_ready, b_done_p, b_busy, b_m2, b_romsel_n, b_rw_n, b_a14, b_a13, b_d0, b_d7;
    logic [2:0] b_level;
    logic [4:0] b_sctl, b_sc0, b_sc1, b_sprg;

    always #5 CLK = ~CLK;

    mmc1_cfg_sequencer dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reset(cmd_reset),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_done(cmd_done), .busy(busy), .fifo_level(fifo_level),
        .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13),
        .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .shadow_control(shadow_control), .shadow_chr0(shadow_chr0),
        .shadow_chr1(shadow_chr1), .shadow_prg(shadow_prg));

    mmc1_cfg_sequencer #(.ROMSEL_DLY(0), .GAP_CLKS(0)) dut_b (
        .CLK(CLK), .RST(RST), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_reset(1'b0),
        .cmd_reg(b_reg), .cmd_data(b_data), .cmd_done(b_done_p), .busy(b_busy), .fifo_level(b_level),
        .CPU_M2(b_m2), .nCPU_ROMSEL(b_romsel_n), .nCPU_RW(b_rw_n), .CPU_A14(b_a14), .CPU_A13(b_a13),
        .CPU_D0(b_d0), .CPU_D7(b_d7), .shadow_control(b_sctl), .shadow_chr0(b_sc0),
        .shadow_chr1(b_sc1), .shadow_prg(b_sprg));

    int errors = 0, checks = 0, cyc = 0;
    wr_t   exp_wr[$];
    done_t exp_done[$];
    logic [4:0] m_ctl = 5'b01100, m_c0 = '0, m_c1 = '0, m_prg = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: queue the bus writes and completion a command must produce
    task automatic expect_cmd(input logic r, input logic [1:0] rg, input logic [4:0] d);
        wr_t w;
        done_t e;
        int n;
        n = 0;
        if (r || AUTO) begin
            w.a = 2'b00; w.d0 = 1'b0; w.d7 = 1'b1;
            exp_wr.push_back(w);
            m_ctl[3:2] = 2'b11;
            n++;
        end
        if (!r) begin
            for (int k = 0; k < 5; k++) begin
                w.a = rg; w.d0 = d[k]; w.d7 = 1'b0;
                exp_wr.push_back(w);
                n++;
            end
            case (rg)
                2'd0:    m_ctl = d;
                2'd1:    m_c0  = d;
                2'd2:    m_c1  = d;
                default: m_prg = d;
            endcase
        end
        e.ctl = m_ctl; e.c0 = m_c0; e.c1 = m_c1; e.prg = m_prg; e.nwr = 8'(n);
        exp_done.push_back(e);
    endtask

    task automatic drive_cmd(input logic r, input logic [1:0] rg, input logic [4:0] d, output int acc);
        int n;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_reset = r; cmd_reg = rg; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("push_accepted", cmd_ready, 1'b1);
        acc = cyc;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic r, input logic [1:0] rg, input logic [4:0] d);
        int acc;
        expect_cmd(r, rg, d);
        drive_cmd(r, rg, d, acc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((busy || exp_done.size() != 0) && n < 2000);
        chk("idle_reached", busy, 1'b0);
    endtask

    // Monitor for the default-timing instance
    logic p_rom = 1'b1, p_m2 = 1'b0, p_rw = 1'b1, in_cmd = 1'b0, have_fall = 1'b0;
    int m2_rise = 0, fall_cyc = 0, start_cyc = 0, nfalls = 0;
    always @(negedge CLK) begin
        wr_t w;
        done_t e;
        if (RST) begin
            in_cmd = 1'b0;
            have_fall = 1'b0;
        end else begin
            if (p_rw && !nCPU_RW && !in_cmd) begin
                in_cmd = 1'b1;
                start_cyc = cyc;
            end
            if (!p_m2 && CPU_M2) m2_rise = cyc;
            if (p_rom && !nCPU_ROMSEL) begin
                nfalls++;
                chk("m2_to_romsel", cyc - m2_rise, 1);
                if (have_fall) chk("write_spacing_ok", (cyc - fall_cyc) >= WR_CLKS, 1'b1);
                have_fall = 1'b1;
                fall_cyc = cyc;
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d d0 %0d d7 %0d, expected none", {CPU_A14, CPU_A13}, CPU_D0, CPU_D7);
                end else begin
                    w = exp_wr.pop_front();
                    chk("write_addr", {CPU_A14, CPU_A13}, w.a);
                    chk("write_d0", CPU_D0, w.d0);
                    chk("write_d7", CPU_D7, w.d7);
                end
            end
            if (!p_rom && nCPU_ROMSEL) chk("romsel_width", cyc - fall_cyc, 5);
            if (cmd_done) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got cmd_done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_latency", cyc - start_cyc, int'(e.nwr) * WR_CLKS);
                    chk("shadow_control", shadow_control, e.ctl);
                    chk("shadow_chr0", shadow_chr0, e.c0);
                    chk("shadow_chr1", shadow_chr1, e.c1);
                    chk("shadow_prg", shadow_prg, e.prg);
                end
                in_cmd = 1'b0;
            end
        end
        p_rom = nCPU_ROMSEL; p_m2 = CPU_M2; p_rw = nCPU_RW;
    end

    // Monitor for the zero-delay / zero-gap instance
    logic pb_m2 = 1'b0, pb_rom = 1'b1, b_done = 1'b0;
    int b_m2_fall = 0, b_fall = 0, b_nf = 0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (pb_m2 && !b_m2) b_m2_fall = cyc;
            if (!pb_m2 && b_m2 && b_nf > 0) chk("b_m2_low_between", cyc - b_m2_fall, 6);
            if (pb_rom && !b_romsel_n) begin
                chk("b_romsel_with_m2", {pb_m2, b_m2}, 2'b01);
                if (b_nf > 0) chk("b_spacing", cyc - b_fall, 12);
                b_fall = cyc;
                b_nf++;
            end
            if (b_done_p) begin
                chk("b_writes", b_nf, NREG);
                b_nf = 0;
                b_done = 1'b1;
            end
        end
        pb_m2 = b_m2; pb_rom = b_romsel_n;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n, acc, base;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_m2", CPU_M2, 1'b0);
        chk("rst_romsel", nCPU_ROMSEL, 1'b1);
        chk("rst_rw", nCPU_RW, 1'b1);
        chk("rst_addr", {CPU_A14, CPU_A13}, 2'b00);
        chk("rst_data", {CPU_D7, CPU_D0}, 2'b00);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", cmd_done, 1'b0);
        chk("rst_shadow_control", shadow_control, 5'b01100);
        chk("rst_shadow_prg", shadow_prg, 5'b00000);
        #1 RST = 1'b0;

        // Boundary timing instance: one CHR1 write
        @(negedge CLK);
        b_valid = 1'b1; b_reg = 2'b10; b_data = 5'b01101;
        @(posedge CLK);
        #1 b_valid = 1'b0;
        n = 0;
        while (!b_done && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("b_done_seen", b_done, 1'b1);
        chk("b_shadow_chr1", b_sc1, 5'b01101);

        // PRG write 10110, plus first-SETUP latency from the accepting edge
        expect_cmd(1'b0, 2'b11, 5'b10110);
        drive_cmd(1'b0, 2'b11, 5'b10110, acc);
        wait_idle();
        chk("first_setup_latency", start_cyc - acc, 3);
        chk("prg_final", shadow_prg, 5'b10110);

        // Control write then a reset command
        push_cmd(1'b0, 2'b00, 5'b00001);
        push_cmd(1'b1, 2'b00, 5'b00000);
        wait_idle();
        chk("ctl_after_reset_cmd", shadow_control, 5'b01101);

        // Backpressure: fill the queue while a command executes
        push_cmd(1'b0, 2'b10, 5'b10101);
        n = 0;
        while (nCPU_RW && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_started", nCPU_RW, 1'b0);
        push_cmd(1'b0, 2'b00, 5'b10011);
        push_cmd(1'b0, 2'b01, 5'b00111);
        push_cmd(1'b0, 2'b11, 5'b11000);
        push_cmd(1'b0, 2'b10, 5'b01010);
        @(negedge CLK);
        chk("full_level", fifo_level, 4);
        chk("full_ready", cmd_ready, 1'b0);
        expect_cmd(1'b1, 2'b00, 5'b00000);
        cmd_valid = 1'b1; cmd_reset = 1'b1; cmd_reg = 2'b00; cmd_data = 5'b00000;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("reopen_ready", cmd_ready, 1'b1);
        chk("reopen_level", fifo_level, 3);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        chk("fifth_accepted_level", fifo_level, 4);
        wait_idle();

        // Abort: reset during the third strobe of a CHR0 write
        expect_cmd(1'b0, 2'b01, 5'b11111);
        void'(exp_done.pop_back());
        while (exp_wr.size() > 3) void'(exp_wr.pop_back());
        base = nfalls;
        drive_cmd(1'b0, 2'b01, 5'b11111, acc);
        n = 0;
        while (nfalls < base + 3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("abort_reached_third", nfalls >= base + 3, 1'b1);
        chk("abort_in_strobe", nCPU_ROMSEL, 1'b0);
        #1 RST = 1'b1;
        m_ctl = 5'b01100; m_c0 = '0; m_c1 = '0; m_prg = '0;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_m2", CPU_M2, 1'b0);
        chk("abort_romsel", nCPU_ROMSEL, 1'b1);
        chk("abort_rw", nCPU_RW, 1'b1);
        chk("abort_level", fifo_level, 0);
        chk("abort_chr0", shadow_chr0, 5'b00000);
        chk("abort_done", cmd_done, 1'b0);
        #1 RST = 1'b0;
        repeat (60) @(negedge CLK);
        chk("abort_idle", busy, 1'b0);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmc1_cfg_sequencer.md
Name: mmc1_cfg_sequencer

Overview:
- Bus-master controller that configures the MMC1 mapper.
- Accepts parallel register-write commands from a host (test harness, loader or debug core) and queues them in a small FIFO.
- Serializes each command into the MMC1 five-write shift protocol by driving the CPU-side strobes (M2, /ROMSEL, R/W, A14/A13, D0, D7) with programmable timing.
- Keeps shadow copies of the mapper registers for readback and checking.

Parameters:
- FIFO_DEPTH, 4: command queue entries (power of 2, ≥2).
- M2_LO_CLKS, 6: clocks M2 is low in SETUP before each write (≥1).
- ROMSEL_DLY, 1: clocks from M2 rise to /ROMSEL fall (≥0; 0 skips DLY).
- M2_HI_CLKS, 5: clocks /ROMSEL is held low (≥1).
- GAP_CLKS, 2: idle clocks after each write (≥0).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high when the FIFO can accept a command.
- cmd_reset  in  1  1 = shift-register reset command (D7 write); cmd_reg/cmd_data ignored.
- cmd_reg  in  2  target register: 00 control, 01 CHR0, 10 CHR1, 11 PRG.
- cmd_data  in  5  register value.
- cmd_done  out  1  one-clock pulse when a command's last write completes.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- CPU_M2  out  1  generated M2.
- nCPU_ROMSEL  out  1  generated /ROMSEL.
- nCPU_RW  out  1  generated R/W (0 = write).
- CPU_A14, CPU_A13  out  1 each  register select.
- CPU_D0, CPU_D7  out  1 each  serial data bit and reset bit.
- shadow_control, shadow_chr0, shadow_chr1, shadow_prg  out  5 each  last value written to each register.

Behaviour:
- Reset (RST high at an edge) gives the following state after that edge:
  - FIFO flushed; fifo_level=0; cmd_ready=1.
  - FSM in IDLE; cmd_done=0; busy=0.
  - Bus outputs: CPU_M2=0, nCPU_ROMSEL=1, nCPU_RW=1, A14/A13=00, D0=0, D7=0.
  - shadow_control=5'b01100; other shadows=0.
  - A reset asserted mid-command aborts immediately; no cmd_done is issued.
- FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready = (fifo_level<FIFO_DEPTH), computed from registered level.
  - Push and pop in the same clock are legal; level is unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle.
  - FIFO entry = {reset, reg[1:0], data[4:0]}.
- FSM states: IDLE, SETUP, DLY, STROBE, RELEASE, GAP.
  - IDLE: if FIFO non-empty, pop, load command and bit counter, go to SETUP. A command pushed into an empty FIFO at edge t gives SETUP outputs after edge t+2.
  - SETUP (M2_LO_CLKS clocks): M2=0, nRW=0, /ROMSEL=1, address and data driven and stable.
  - DLY (ROMSEL_DLY clocks): M2=1, /ROMSEL=1.
  - STROBE (M2_HI_CLKS clocks): M2=1, /ROMSEL=0.
  - RELEASE (1 clock): M2=1, /ROMSEL=1.
  - GAP (GAP_CLKS clocks): M2=0, nRW=1, D0/D7=0.
  - After GAP: if more bits remain, return to SETUP; otherwise pulse cmd_done and go to IDLE.
  - With GAP_CLKS=0, GAP is skipped.
- Address and data are stable from SETUP entry through RELEASE.
- Clocks per write = M2_LO_CLKS+ROMSEL_DLY+M2_HI_CLKS+1+GAP_CLKS (15 at defaults).
- Register command:
  - 5 writes, D7=0, D0=data[k] for write k=0..4 (LSB first).
  - A14/A13=cmd_reg for all 5 writes.
  - On completion, the selected shadow register takes cmd_data.
- Reset command:
  - 1 write, D7=1, D0=0, A14/A13=00.
  - On completion, shadow_control[3:2] takes 2'b11; all other shadow bits are unchanged.
- cmd_done is coincident with the shadow update: both occur on the last GAP edge, or the RELEASE edge if GAP_CLKS=0.
- No two /ROMSEL falling edges are closer than the per-write clock count.

Optional Feature:
- MMC1_AUTO_RESET_EN defined: every register command is prefixed by one reset write (D7=1, A=00).
  - 6 writes per register command.
  - shadow_control[3:2] is set by the prefix, then the target register is updated.
  - Guarantees shift-register alignment after an aborted sequence.
  - cmd_done fires only after the 6th write.
- MMC1_AUTO_RESET_EN undefined: register commands are exactly 5 writes.

Test Plan:
- Reset: pulse RST → CPU_M2=0, nCPU_ROMSEL=1, nCPU_RW=1, cmd_ready=1, fifo_level=0, shadow_control=01100, shadow_prg=0.
- PRG write, data 10110, reg 11 (defaults):
  - 5 /ROMSEL low pulses of 5 clocks each, spaced 15 clocks apart.
  - D0 sequence 0,1,1,0,1; A14/A13=11; D7=0.
  - cmd_done 75 clocks after first SETUP; shadow_prg=10110.
  - With MMC1_AUTO_RESET_EN defined: 6 pulses, the first with D7=1, and cmd_done after 90 clocks.
- Reset command after control write 00001 → one pulse with D7=1, A=00; shadow_control=01101; cmd_done after 15 clocks.
- Backpressure: while the FSM is executing a command, push 4 commands → fifo_level=4, cmd_ready=0; a 5th held valid is accepted on the clock after the next pop. Commands are executed in order.
- Abort: assert RST during the 3rd STROBE of a CHR0 write → idle bus levels after the next edge, fifo_level=0, shadow_chr0=0, no cmd_done.
- Timing at boundaries: with ROMSEL_DLY=0 and GAP_CLKS=0 → /ROMSEL falls on the same edge M2 rises; writes are 12 clocks apart; M2 low never exceeds M2_LO_CLKS between writes.
